// File: rtl/dram_arbiter_if.sv
// Requester-side bus of the DRAM arbiter: two request ports plus shared ack/rdata/busy.
// The arbiter uses the slave view; a requester or bench uses the master view.
interface dram_arbiter_if #(
   parameter int ADDR_W = 16
);
   logic [1:0]        req_i;
   logic [1:0]        we_i;
   logic [ADDR_W-1:0] adr0_i;
   logic [ADDR_W-1:0] adr1_i;
   logic [31:0]       wd0_i;
   logic [31:0]       wd1_i;
   logic [1:0]        sel0_i;
   logic [1:0]        sel1_i;
   logic [1:0]        ack_o;
   logic [31:0]       rdata_o;
   logic              busy_o;

   modport slave (
      input  req_i, we_i, adr0_i, adr1_i, wd0_i, wd1_i, sel0_i, sel1_i,
      output ack_o, rdata_o, busy_o
   );

   modport master (
      output req_i, we_i, adr0_i, adr1_i, wd0_i, wd1_i, sel0_i, sel1_i,
      input  ack_o, rdata_o, busy_o
   );
endinterface

// File: rtl/dram_arbiter.sv
// Two-port arbiter in front of the word-wide data DRAM: one access in flight,
// sub-word stores as read-modify-write, sign-extended sub-word loads.
module dram_arbiter #(
   parameter int ADDR_W = 16,
   parameter bit RR_EN  = 1'b1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   dram_arbiter_if.slave     bus,
   output logic [ADDR_W-3:0] ram_adr_o,
   output logic              ram_we_o,
   output logic [31:0]       ram_wd_o,
   input  logic [31:0]       ram_rd_i
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ACCESS   = 2'd1,
      S_MERGE_WR = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_port;
   logic              r_last_grant;
   logic              r_we;
   logic [ADDR_W-1:0] r_adr;
   logic [31:0]       r_wd;
   logic [1:0]        r_sel;
   logic [31:0]       r_merge;
   logic [31:0]       r_rdata;
   logic              w_port;
   logic              w_any_req;
   logic              w_word;

   // Load lane extraction: byte by adr[1:0], half by adr[1], sign-extended.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  sel);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] v;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (sel)
         2'b00:   v = {{24{b[7]}}, b};
         2'b01:   v = {{16{h[15]}}, h};
         default: v = word;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [1:0]  lane,
                                               input logic        half);
      logic [31:0] m;
      m = old;
      if (half) begin
         if (lane[1]) m[31:16] = wd[15:0];
         else         m[15:0]  = wd[15:0];
      end else begin
         case (lane)
            2'd0:    m[7:0]   = wd[7:0];
            2'd1:    m[15:8]  = wd[7:0];
            2'd2:    m[23:16] = wd[7:0];
            default: m[31:24] = wd[7:0];
         endcase
      end
      return m;
   endfunction

   assign w_any_req = |bus.req_i;
   assign w_word    = r_sel[1];
   assign ram_adr_o = r_adr[ADDR_W-1:2];
   assign bus.rdata_o = r_rdata;

   // Winner: a lone requester wins; on a tie, round-robin or fixed port 0.
   always_comb begin
      w_port = 1'b0;
      case (bus.req_i)
         2'b10:   w_port = 1'b1;
         2'b11:   w_port = RR_EN ? ~r_last_grant : 1'b0;
         default: w_port = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      ram_we_o    = 1'b0;
      ram_wd_o    = 32'h0;
      bus.ack_o   = 2'b00;
      bus.busy_o  = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (w_any_req) w_next = S_ACCESS;
         end
         S_ACCESS: begin
            if (r_we && !w_word) begin
               w_next = S_MERGE_WR;
            end else begin
               w_next = S_DONE;
            end
            if (r_we && w_word) begin
               ram_we_o = 1'b1;
               ram_wd_o = r_wd;
            end
         end
         S_MERGE_WR: begin
            w_next   = S_DONE;
            ram_we_o = 1'b1;
            ram_wd_o = merge_lanes(r_merge, r_wd, r_adr[1:0], r_sel[0]);
         end
         S_DONE: begin
            w_next    = S_IDLE;
            bus.ack_o = r_port ? 2'b10 : 2'b01;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Grant latch in IDLE, load capture / RMW read in ACCESS.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_port       <= 1'b0;
         r_last_grant <= 1'b1;
         r_we         <= 1'b0;
         r_adr        <= '0;
         r_wd         <= 32'h0;
         r_sel        <= 2'b00;
         r_merge      <= 32'h0;
         r_rdata      <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_port       <= w_port;
                  r_last_grant <= w_port;
                  r_we         <= bus.we_i[w_port];
                  r_adr        <= w_port ? bus.adr1_i : bus.adr0_i;
                  r_wd         <= w_port ? bus.wd1_i  : bus.wd0_i;
                  r_sel        <= w_port ? bus.sel1_i : bus.sel0_i;
               end
            end
            S_ACCESS: begin
               if (!r_we) begin
                  r_rdata <= load_extract(ram_rd_i, r_adr[1:0], r_sel);
               end else if (!w_word) begin
                  r_merge <= ram_rd_i;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: expected acks/loads are queued at issue time
// and compared when the arbiter acks; a bench-side word memory models the DRAM.
module tb_dram_arbiter;
   localparam int ADDR_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
   dram_arbiter_if #(.ADDR_W(ADDR_W)) fp ();

   logic [ADDR_W-3:0] ram_adr;
   logic              ram_we;
   logic [31:0]       ram_wd;
   logic [31:0]       ram_rd;
   logic [ADDR_W-3:0] fp_adr;
   logic              fp_we;
   logic [31:0]       fp_wd;

   logic [31:0]       mem [0:(1<<(ADDR_W-2))-1];
   logic              pl_en;
   logic [ADDR_W-3:0] pl_adr;
   logic [31:0]       pl_dat;

   int n_vec = 0;
   int n_miss = 0;
   int cyc = 0;
   int last_ack = 0;

   typedef struct {
      logic [1:0]  ack;
      bit          chk_rd;
      logic [31:0] rd;
      int          lat;
      int          t0;
   } exp_t;
   exp_t sb[$];

   dram_arbiter #(.ADDR_W(ADDR_W), .RR_EN(1'b1)) u_dut (
      .clk_i(clk), .reset_i(rst), .bus(bus),
      .ram_adr_o(ram_adr), .ram_we_o(ram_we), .ram_wd_o(ram_wd), .ram_rd_i(ram_rd)
   );

   dram_arbiter #(.ADDR_W(ADDR_W), .RR_EN(1'b0)) u_dut_fp (
      .clk_i(clk), .reset_i(rst), .bus(fp),
      .ram_adr_o(fp_adr), .ram_we_o(fp_we), .ram_wd_o(fp_wd), .ram_rd_i(32'h0)
   );

   assign ram_rd = mem[ram_adr];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_we)     mem[ram_adr] <= ram_wd;
      else if (pl_en) mem[pl_adr]  <= pl_dat;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [ADDR_W-3:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_adr = a; pl_dat = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic push_exp(input logic [1:0] ack, input bit chk_rd,
                           input logic [31:0] rd, input int lat);
      exp_t e;
      e.ack = ack; e.chk_rd = chk_rd; e.rd = rd; e.lat = lat; e.t0 = cyc;
      sb.push_back(e);
   endtask

   task automatic drive(input bit p, input bit we, input logic [ADDR_W-1:0] adr,
                        input logic [31:0] wd, input logic [1:0] sel);
      if (!p) begin
         bus.we_i[0] = we; bus.adr0_i = adr; bus.wd0_i = wd; bus.sel0_i = sel;
      end else begin
         bus.we_i[1] = we; bus.adr1_i = adr; bus.wd1_i = wd; bus.sel1_i = sel;
      end
      bus.req_i[p] = 1'b1;
   endtask

   task automatic issue(input bit p, input bit we, input logic [ADDR_W-1:0] adr,
                        input logic [31:0] wd, input logic [1:0] sel,
                        input bit chk_rd, input logic [31:0] rd, input int lat);
      drive(p, we, adr, wd, sel);
      push_exp(p ? 2'b10 : 2'b01, chk_rd, rd, lat);
   endtask

   // Wait (bounded) for the next ack, score it, then confirm it was a single-cycle pulse.
   task automatic collect(input bit drop, input bit on_fp);
      exp_t       e;
      logic [1:0] a;
      bit         got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         a = on_fp ? fp.ack_o : bus.ack_o;
         if (a != 2'b00) begin
            got = 1'b1;
            last_ack = cyc;
            if (sb.size() == 0) begin
               chk("unexpected_ack", {30'd0, a}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("ack_port", {30'd0, a}, {30'd0, e.ack});
               if (e.lat >= 0) chk("latency", cyc - e.t0, e.lat);
               if (e.chk_rd) chk("rdata", bus.rdata_o, e.rd);
            end
            if (drop) begin
               if (on_fp) fp.req_i  = fp.req_i  & ~a;
               else       bus.req_i = bus.req_i & ~a;
            end
         end
      end
      if (!got) begin
         chk("ack_timeout", 32'd0, 32'd1);
      end else begin
         @(negedge clk);
         chk("ack_one_cycle", {30'd0, (on_fp ? fp.ack_o : bus.ack_o)}, 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int a1;
      pl_en = 1'b0; pl_adr = '0; pl_dat = 32'h0;
      bus.req_i = 2'b00; bus.we_i = 2'b00;
      bus.adr0_i = '0; bus.adr1_i = '0; bus.wd0_i = 32'h0; bus.wd1_i = 32'h0;
      bus.sel0_i = 2'b00; bus.sel1_i = 2'b00;
      fp.req_i = 2'b00; fp.we_i = 2'b00;
      fp.adr0_i = '0; fp.adr1_i = '0; fp.wd0_i = 32'h0; fp.wd1_i = 32'h0;
      fp.sel0_i = 2'b00; fp.sel1_i = 2'b00;

      repeat (3) @(negedge clk);
      chk("rst_ack",     {30'd0, bus.ack_o}, 32'd0);
      chk("rst_rdata",   bus.rdata_o, 32'h0);
      chk("rst_busy",    {31'd0, bus.busy_o}, 32'd0);
      chk("rst_ram_we",  {31'd0, ram_we}, 32'd0);
      chk("rst_ram_adr", {18'd0, ram_adr}, 32'd0);
      chk("rst_ram_wd",  ram_wd, 32'h0);
      rst = 1'b0;

      // Byte load, lane 3
      preload(14'd4, 32'h11223344);
      issue(1'b0, 1'b0, 16'h0013, 32'h0, 2'b00, 1'b1, 32'h00000011, 2);
      collect(1'b1, 1'b0);

      // Half and byte loads with sign extension
      preload(14'd4, 32'h80FF7F00);
      issue(1'b0, 1'b0, 16'h0012, 32'h0, 2'b01, 1'b1, 32'hFFFF80FF, 2);
      collect(1'b1, 1'b0);
      issue(1'b0, 1'b0, 16'h0010, 32'h0, 2'b01, 1'b1, 32'h00007F00, 2);
      collect(1'b1, 1'b0);
      issue(1'b1, 1'b0, 16'h0012, 32'h0, 2'b00, 1'b1, 32'hFFFFFFFF, 2);
      collect(1'b1, 1'b0);
      issue(1'b0, 1'b0, 16'h0013, 32'h0, 2'b00, 1'b1, 32'hFFFFFF80, 2);
      collect(1'b1, 1'b0);
      issue(1'b0, 1'b0, 16'h0011, 32'h0, 2'b00, 1'b1, 32'h0000007F, 2);
      collect(1'b1, 1'b0);

      // Byte store as read-modify-write from port 1
      preload(14'd4, 32'hAABBCCDD);
      issue(1'b1, 1'b1, 16'h0011, 32'h000000EE, 2'b00, 1'b0, 32'h0, 3);
      @(negedge clk);
      chk("sb_access_we",  {31'd0, ram_we}, 32'd0);
      chk("sb_access_adr", {18'd0, ram_adr}, 32'd4);
      @(negedge clk);
      chk("sb_merge_we", {31'd0, ram_we}, 32'd1);
      chk("sb_merge_wd", ram_wd, 32'hAABBEEDD);
      collect(1'b1, 1'b0);
      chk("sb_mem", mem[4], 32'hAABBEEDD);
      chk("rdata_hold", bus.rdata_o, 32'h0000007F);

      // Reset during MERGE_WR abandons the write and the ack
      preload(14'd8, 32'hCAFEF00D);
      drive(1'b0, 1'b1, 16'h0022, 32'h00001234, 2'b01);
      @(negedge clk);
      @(negedge clk);
      chk("sh_merge_we", {31'd0, ram_we}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_we",   {31'd0, ram_we}, 32'd0);
      chk("rst_mid_ack",  {30'd0, bus.ack_o}, 32'd0);
      chk("rst_mid_busy", {31'd0, bus.busy_o}, 32'd0);
      bus.req_i = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid_mem",  mem[8], 32'hCAFEF00D);
      chk("rst_mid_idle", {30'd0, bus.ack_o}, 32'd0);

      // Round-robin from reset: both ports hold word writes
      bus.we_i = 2'b11; bus.sel0_i = 2'b11; bus.sel1_i = 2'b11;
      bus.adr0_i = 16'h0040; bus.wd0_i = 32'h0A0A0A0A;
      bus.adr1_i = 16'h0044; bus.wd1_i = 32'h0B0B0B0B;
      bus.req_i = 2'b11;
      push_exp(2'b01, 1'b0, 32'h0, -1);
      push_exp(2'b10, 1'b0, 32'h0, -1);
      push_exp(2'b01, 1'b0, 32'h0, -1);
      push_exp(2'b10, 1'b0, 32'h0, -1);
      for (int k = 0; k < 4; k++) collect(1'b0, 1'b0);
      bus.req_i = 2'b00;
      chk("rr_mem0", mem[16], 32'h0A0A0A0A);
      chk("rr_mem1", mem[17], 32'h0B0B0B0B);

      // Fixed priority: port 0 every time
      fp.we_i = 2'b11; fp.sel0_i = 2'b11; fp.sel1_i = 2'b11;
      fp.adr0_i = 16'h0080; fp.wd0_i = 32'h01010101;
      fp.adr1_i = 16'h0084; fp.wd1_i = 32'h02020202;
      fp.req_i = 2'b11;
      for (int k = 0; k < 4; k++) push_exp(2'b01, 1'b0, 32'h0, -1);
      for (int k = 0; k < 4; k++) collect(1'b0, 1'b1);
      fp.req_i = 2'b00;
      chk("fp_idle_we", {31'd0, fp_we}, 32'd0);
      chk("fp_adr",     {18'd0, fp_adr}, 32'h20);
      chk("fp_idle_wd", fp_wd, 32'h0);

      // Word store then word load back-to-back
      @(negedge clk);
      issue(1'b0, 1'b1, 16'h0008, 32'hDEADBEEF, 2'b11, 1'b0, 32'h0, 2);
      collect(1'b1, 1'b0);
      a1 = last_ack;
      issue(1'b0, 1'b0, 16'h0008, 32'h0, 2'b11, 1'b1, 32'hDEADBEEF, 2);
      collect(1'b1, 1'b0);
      chk("b2b_gap", last_ack - a1, 32'd3);
      chk("sw_mem", mem[2], 32'hDEADBEEF);

      // Request dropped before ack still completes
      issue(1'b1, 1'b0, 16'h0008, 32'h0, 2'b10, 1'b1, 32'hDEADBEEF, 2);
      @(negedge clk);
      bus.req_i[1] = 1'b0;
      collect(1'b1, 1'b0);

      if (sb.size() != 0) chk("sb_leftover", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
